seven_seg_display_driver: RTL and testbench

//  Downstream consumer of the processor top's displayV0/displayV1 debug outputs.

---
 rtl/seven_seg_display_driver.sv | 205 ++++++++++++++++++++
 tb/tb_seven_seg_display_driver.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_display_driver.sv
// Seven-segment display driver for the processor debug registers.
// Snapshots displayV0 or displayV1 once per refresh frame and scans the value
// as hex across a common-anode multi-digit display. A debounced push-button
// toggles which register is captured at the next frame boundary.
module seven_seg_display_driver #(
   parameter int NUM_DIGITS      = 8,
   parameter int REFRESH_DIV     = 100000,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int BLANK_LZ        = 1
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic [31:0]           displayV0,
   input  logic [31:0]           displayV1,
   input  logic                  btn,
   output logic [NUM_DIGITS-1:0] an,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic                  shown_sel
);

   localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int PRE_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int SNAP_W = 4 * NUM_DIGITS;

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } dbState_t;

   // Scan state
   logic [PRE_W-1:0]  prescaler;
   logic [IDX_W-1:0]  digitIdx;
   logic              tick;
   logic              frameWrap;
   logic [SNAP_W-1:0] snapshot;

   // Display decode
   logic [3:0]            curNib;
   logic [IDX_W-1:0]      topIdx;
   logic                  blankDigit;
   logic [NUM_DIGITS-1:0] anNext;
   logic [6:0]            segNext;
   logic                  dpNext;

   // Button path
   logic             btnMeta;
   logic             btnSync;
   dbState_t         dbState;
   dbState_t         dbNext;
   logic [CNT_W-1:0] dbCount;
   logic             selToggle;
   logic             sel;

   // Hex nibble to active-low segment pattern {g,f,e,d,c,b,a}
   function automatic logic [6:0] hexToSeg(input logic [3:0] nib);
      logic [6:0] pat;
      case (nib)
         4'h0:    pat = 7'b1000000;
         4'h1:    pat = 7'b1111001;
         4'h2:    pat = 7'b0100100;
         4'h3:    pat = 7'b0110000;
         4'h4:    pat = 7'b0011001;
         4'h5:    pat = 7'b0010010;
         4'h6:    pat = 7'b0000010;
         4'h7:    pat = 7'b1111000;
         4'h8:    pat = 7'b0000000;
         4'h9:    pat = 7'b0010000;
         4'hA:    pat = 7'b0001000;
         4'hB:    pat = 7'b0000011;
         4'hC:    pat = 7'b1000110;
         4'hD:    pat = 7'b0100001;
         4'hE:    pat = 7'b0000110;
         default: pat = 7'b0001110;
      endcase
      return pat;
   endfunction

   assign tick      = (prescaler == PRE_LAST);
   assign frameWrap = tick && (digitIdx == IDX_LAST);

   // Prescaler and digit index: advance one digit per refresh period
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         prescaler <= '0;
         digitIdx  <= '0;
      end else if (tick) begin
         prescaler <= '0;
         digitIdx  <= (digitIdx == IDX_LAST) ? '0 : digitIdx + IDX_W'(1);
      end else begin
         prescaler <= prescaler + PRE_W'(1);
      end
   end

   // Frame snapshot: capture the selected register only when the scan wraps
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         snapshot  <= '0;
         shown_sel <= 1'b0;
      end else if (frameWrap) begin
         snapshot  <= sel ? displayV1[SNAP_W-1:0] : displayV0[SNAP_W-1:0];
         shown_sel <= sel;
      end
   end

   // Digit decode: pick the active nibble and find the highest nonzero nibble for blanking
   always_comb begin
      curNib = 4'h0;
      topIdx = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (snapshot[4*i +: 4] != 4'h0) topIdx = IDX_W'(i);
         if (digitIdx == IDX_W'(i))      curNib = snapshot[4*i +: 4];
      end
      blankDigit = (BLANK_LZ != 0) && (digitIdx > topIdx);
      segNext    = blankDigit ? 7'h7F : hexToSeg(curNib);
      anNext     = ~(NUM_DIGITS'(1) << digitIdx);
      dpNext     = ~((digitIdx == '0) && shown_sel);
   end

   // Output registers: one cycle behind the scan index, blank while in reset
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         an  <= '1;
         seg <= 7'h7F;
         dp  <= 1'b1;
      end else begin
         an  <= anNext;
         seg <= segNext;
         dp  <= dpNext;
      end
   end

   // Two-flop synchronizer for the asynchronous button
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         btnMeta <= 1'b0;
         btnSync <= 1'b0;
      end else begin
         btnMeta <= btn;
         btnSync <= btnMeta;
      end
   end

   // Debounce state register; the stability counter restarts on every state change
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         dbState <= IDLE;
         dbCount <= '0;
      end else begin
         dbState <= dbNext;
         if (dbNext != dbState) begin
            dbCount <= '0;
         end else if (dbState == PRESS_WAIT || dbState == RELEASE_WAIT) begin
            dbCount <= dbCount + CNT_W'(1);
         end
      end
   end

   // Debounce next-state: a press toggles once, a release must settle before re-arming
   always_comb begin
      dbNext    = dbState;
      selToggle = 1'b0;
      case (dbState)
         IDLE: begin
            if (btnSync) dbNext = PRESS_WAIT;
         end
         PRESS_WAIT: begin
            if (!btnSync) begin
               dbNext = IDLE;
            end else if (dbCount == CNT_LAST) begin
               dbNext    = HELD;
               selToggle = 1'b1;
            end
         end
         HELD: begin
            if (!btnSync) dbNext = RELEASE_WAIT;
         end
         RELEASE_WAIT: begin
            if (btnSync) begin
               dbNext = HELD;
            end else if (dbCount == CNT_LAST) begin
               dbNext = IDLE;
            end
         end
         default: dbNext = IDLE;
      endcase
   end

   // Register select: flips on each accepted press, takes effect at the next frame wrap
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         sel <= 1'b0;
      end else if (selToggle) begin
         sel <= ~sel;
      end
   end

endmodule

// File: tb/tb_seven_seg_display_driver.sv
// Testbench for seven_seg_display_driver: frame-level reference model feeding a
// scoreboard queue, with a monitor that pops one entry per digit presented.
module tb_seven_seg_display_driver;

   localparam int ND    = 8;
   localparam int RD    = 4;
   localparam int DC    = 8;
   localparam int FRAME = ND * RD;

   logic        Clk = 1'b0;
   logic        Reset = 1'b0;
   logic [31:0] displayV0 = 32'h0;
   logic [31:0] displayV1 = 32'h0;
   logic        btn = 1'b0;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        shown_sel;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int         idx;
      logic [6:0] seg;
      logic       dp;
      logic       sel;
   } exp_t;

   exp_t expQ[$];

   logic [6:0] hexTbl [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   seven_seg_display_driver #(
      .NUM_DIGITS      (ND),
      .REFRESH_DIV     (RD),
      .DEBOUNCE_CYCLES (DC),
      .BLANK_LZ        (1)
   ) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .displayV0 (displayV0),
      .displayV1 (displayV1),
      .btn       (btn),
      .an        (an),
      .seg       (seg),
      .dp        (dp),
      .shown_sel (shown_sel)
   );

   always #5 Clk = ~Clk;

   // Expected contents of one whole frame: digit i shows nibble i, blank above the top nonzero nibble
   function automatic void pushFrame(input logic [31:0] v, input logic s);
      exp_t        e;
      logic [31:0] upper;
      logic [3:0]  nib;
      for (int i = 0; i < ND; i++) begin
         upper = v >> (4 * i);
         nib   = upper[3:0];
         e.idx = i;
         e.seg = (i > 0 && upper == 32'h0) ? 7'h7F : hexTbl[nib];
         e.dp  = (i == 0 && s) ? 1'b0 : 1'b1;
         e.sel = s;
         expQ.push_back(e);
      end
   endfunction

   // Reference model: counts clock edges since reset, captures a frame every FRAME edges,
   // and decides accepted presses from run lengths of the synchronized button level.
   int   edgeN = 0;
   logic modelSel = 1'b0;
   initial begin : model
      logic sh0, sh1, btnS, armed;
      int   hiRun, loRun;
      sh0 = 1'b0; sh1 = 1'b0; armed = 1'b1; hiRun = 0; loRun = 0;
      forever begin
         @(posedge Clk or negedge Reset);
         if (!Reset) begin
            edgeN = 0; sh0 = 1'b0; sh1 = 1'b0; modelSel = 1'b0;
            armed = 1'b1; hiRun = 0; loRun = 0;
            expQ.delete();
         end else begin
            edgeN++;
            if (edgeN == 1) pushFrame(32'h0, 1'b0);
            btnS = sh1;
            sh1  = sh0;
            sh0  = btn;
            if (edgeN % FRAME == 0) pushFrame(modelSel ? displayV1 : displayV0, modelSel);
            if (armed) begin
               if (btnS) begin
                  hiRun++;
                  if (hiRun == DC + 1) begin
                     modelSel = ~modelSel; armed = 1'b0; hiRun = 0; loRun = 0;
                  end
               end else begin
                  hiRun = 0;
               end
            end else begin
               if (!btnS) begin
                  loRun++;
                  if (loRun == DC + 1) begin
                     armed = 1'b1; loRun = 0; hiRun = 0;
                  end
               end else begin
                  loRun = 0;
               end
            end
         end
      end
   end

   // Monitor: a change of the lit digit is a presented output; pop and compare it
   initial begin : monitor
      logic [7:0] prevAn, expAn;
      int         runLen;
      logic       haveCur;
      exp_t       cur;
      prevAn = 8'hFF; runLen = 0; haveCur = 1'b0;
      forever begin
         @(negedge Clk);
         if (!Reset) begin
            total++;
            if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1 || shown_sel !== 1'b0) begin
               bad++;
               $display("FAIL reset_outputs: got an=%h seg=%b dp=%b shown_sel=%b, want an=ff seg=1111111 dp=1 shown_sel=0",
                        an, seg, dp, shown_sel);
            end
            prevAn = 8'hFF; runLen = 0; haveCur = 1'b0;
         end else if (an !== prevAn) begin
            if (haveCur) begin
               total++;
               if (runLen != RD) begin
                  bad++;
                  $display("FAIL digit_dwell: digit %0d lit %0d cycles, want %0d", cur.idx, runLen, RD);
               end
            end
            total++;
            if (expQ.size() == 0) begin
               bad++;
               haveCur = 1'b0;
               $display("FAIL scoreboard_empty: got an=%h seg=%b with no expected entry", an, seg);
            end else begin
               cur     = expQ.pop_front();
               haveCur = 1'b1;
               expAn   = ~(8'd1 << cur.idx);
               if ({an, seg, dp, shown_sel} !== {expAn, cur.seg, cur.dp, cur.sel}) begin
                  bad++;
                  $display("FAIL digit_present: got an=%h seg=%b dp=%b shown_sel=%b, want an=%h seg=%b dp=%b shown_sel=%b",
                           an, seg, dp, shown_sel, expAn, cur.seg, cur.dp, cur.sel);
               end
            end
            prevAn = an;
            runLen = 1;
         end else begin
            runLen++;
            if (haveCur) begin
               total++;
               if (seg !== cur.seg || dp !== cur.dp) begin
                  bad++;
                  $display("FAIL digit_hold: digit %0d got seg=%b dp=%b, want seg=%b dp=%b",
                           cur.idx, seg, dp, cur.seg, cur.dp);
               end
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge Clk);
         #1;
      end
   endtask

   task automatic checkResetNow(input string tag);
      total++;
      if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1 || shown_sel !== 1'b0) begin
         bad++;
         $display("FAIL %s: got an=%h seg=%b dp=%b shown_sel=%b, want an=ff seg=1111111 dp=1 shown_sel=0",
                  tag, an, seg, dp, shown_sel);
      end
   endtask

   task automatic midFrameReset(input int holdCycles);
      #2 Reset = 1'b0;
      #1 checkResetNow("reset_async");
      cyc(holdCycles);
      Reset = 1'b1;
   endtask

   task automatic press(input int highCycles, input int lowCycles);
      btn = 1'b1;
      cyc(highCycles);
      btn = 1'b0;
      cyc(lowCycles);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int r;
      // Reset held for three cycles, then released; then a reset mid-frame
      Reset = 1'b0;
      cyc(3);
      checkResetNow("reset_hold");
      Reset = 1'b1;
      cyc(13);
      midFrameReset(2);

      // Fixed value with leading zeros on V0
      displayV0 = 32'h0000_12AB;
      displayV1 = $urandom;
      cyc(2 * FRAME + 2);

      // Short glitch rejected, long press accepted
      press(3, 12);
      press(20, 20);
      cyc(2 * FRAME);

      // Press, then bouncy release; then a clean press to confirm the button re-arms
      btn = 1'b1;
      cyc(15);
      for (int k = 0; k < 5; k++) begin
         btn = (k % 2 == 0) ? 1'b0 : 1'b1;
         cyc(2);
      end
      btn = 1'b0;
      cyc(20);
      press(12, 14);
      press(12, 14);
      cyc(FRAME);

      // Input change while digit 3 is lit is not seen until the next wrap
      displayV0 = 32'h1;
      cyc(FRAME + 4);
      for (int k = 0; k < FRAME && (edgeN % FRAME) != 14; k++) cyc(1);
      displayV0 = 32'h2;
      cyc(2 * FRAME);

      // Boundary values
      displayV0 = 32'h0;
      cyc(2 * FRAME);
      displayV0 = 32'hFFFF_FFFF;
      cyc(2 * FRAME);

      // Randomized mix of register updates, button activity and occasional resets
      for (int it = 0; it < 90; it++) begin
         r = $urandom_range(0, 19);
         if (r < 6) begin
            displayV0 = $urandom >> $urandom_range(0, 31);
         end else if (r < 10) begin
            displayV1 = $urandom >> $urandom_range(0, 31);
         end else if (r < 15) begin
            btn = ~btn;
         end else if (r < 19) begin
            press($urandom_range(8, 16), $urandom_range(6, 14));
         end else begin
            midFrameReset($urandom_range(1, 3));
         end
         cyc($urandom_range(1, 20));
      end

      btn = 1'b0;
      cyc(FRAME + 2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
